// File: rtl/can_bit_destuff.sv
// CAN receive front-end: pin synchronizer, SOF hard sync, per-bit sample strobe,
// stuff-bit removal / stuff-error detection and bus-idle tracking.
module can_bit_destuff #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned SAMPLE_POINT = 7,
  parameter int unsigned IDLE_BITS    = 11
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Rx_Serial,
  input  logic i_Stuff_En,
  output logic o_Sample,
  output logic o_Rx_Bit,
  output logic o_Ignora_bit,
  output logic o_Erro_Flag,
  output logic o_Sof,
  output logic o_Bus_Idle
);

  localparam int unsigned CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDLE_W = $clog2(IDLE_BITS + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_SP  = CNT_W'(SAMPLE_POINT);
  localparam logic [IDLE_W-1:0] IDLE_N  = IDLE_W'(IDLE_BITS);

  typedef enum logic [2:0] {
    IDLE_WAIT,
    BUS_IDLE,
    SOF_CHECK,
    RECEIVING,
    ERROR_WAIT
  } state_t;

  state_t            state;
  logic              sync1;
  logic              sync2;
  logic              sync_prev;
  logic [CNT_W-1:0]  clk_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] rec_cnt;
  logic [2:0]        run_cnt;
  logic              last_bit;

  logic              fall_c;
  logic              hard_sync_c;
  logic              at_sample_c;
  logic [IDLE_W-1:0] idle_inc_c;
  logic [IDLE_W-1:0] rec_inc_c;

  // Edge detect, sample-point decode and saturating increments.
  // The hard-sync cycle itself counts as clk_cnt=0, so it never hits the sample point.
  always_comb begin
    fall_c      = sync_prev & ~sync2;
    hard_sync_c = fall_c && ((state == IDLE_WAIT) || (state == BUS_IDLE));
    at_sample_c = !hard_sync_c && (state != BUS_IDLE) && (clk_cnt == CNT_SP);
    idle_inc_c  = (idle_cnt == IDLE_N) ? idle_cnt : idle_cnt + IDLE_W'(1);
    rec_inc_c   = (rec_cnt == IDLE_N) ? rec_cnt : rec_cnt + IDLE_W'(1);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= IDLE_WAIT;
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      sync_prev    <= 1'b1;
      clk_cnt      <= '0;
      idle_cnt     <= '0;
      rec_cnt      <= '0;
      run_cnt      <= '0;
      last_bit     <= 1'b0;
      o_Sample     <= 1'b0;
      o_Rx_Bit     <= 1'b1;
      o_Ignora_bit <= 1'b0;
      o_Erro_Flag  <= 1'b0;
      o_Sof        <= 1'b0;
      o_Bus_Idle   <= 1'b0;
    end else begin
      sync1     <= i_Rx_Serial;
      sync2     <= sync1;
      sync_prev <= sync2;
      o_Sample  <= 1'b0;
      o_Sof     <= 1'b0;

      // Bit timer: stopped while the bus is idle, restarted by a hard sync.
      if (hard_sync_c) begin
        clk_cnt <= CNT_W'(1);
      end else if (state != BUS_IDLE) begin
        clk_cnt <= (clk_cnt == CNT_MAX) ? '0 : clk_cnt + CNT_W'(1);
      end

      case (state)
        IDLE_WAIT: begin
          if (fall_c) begin
            idle_cnt <= '0;
          end else if (at_sample_c) begin
            if (!sync2) begin
              idle_cnt <= '0;
            end else if (idle_inc_c == IDLE_N) begin
              idle_cnt    <= '0;
              state       <= BUS_IDLE;
              o_Bus_Idle  <= 1'b1;
              o_Erro_Flag <= 1'b0;
            end else begin
              idle_cnt <= idle_inc_c;
            end
          end
        end

        BUS_IDLE: begin
          if (fall_c) begin
            state      <= SOF_CHECK;
            o_Bus_Idle <= 1'b0;
          end
        end

        SOF_CHECK: begin
          if (at_sample_c) begin
            if (!sync2) begin
              state        <= RECEIVING;
              o_Sample     <= 1'b1;
              o_Sof        <= 1'b1;
              o_Rx_Bit     <= 1'b0;
              o_Ignora_bit <= 1'b0;
              o_Erro_Flag  <= 1'b0;
              run_cnt      <= 3'd1;
              last_bit     <= 1'b0;
              rec_cnt      <= '0;
            end else begin
              state       <= BUS_IDLE;
              o_Bus_Idle  <= 1'b1;
              o_Erro_Flag <= 1'b0;
            end
          end
        end

        RECEIVING, ERROR_WAIT: begin
          if (at_sample_c) begin
            o_Sample     <= 1'b1;
            o_Rx_Bit     <= sync2;
            o_Ignora_bit <= 1'b0;
            o_Erro_Flag  <= 1'b0;
            rec_cnt      <= sync2 ? rec_inc_c : '0;

            // Stuff rule: after five equal bits the next must differ and is dropped.
            if (state == RECEIVING) begin
              if (!i_Stuff_En) begin
                run_cnt <= '0;
              end else if (run_cnt == 3'd0) begin
                run_cnt  <= 3'd1;
                last_bit <= sync2;
              end else if (run_cnt == 3'd5) begin
                if (sync2 != last_bit) begin
                  o_Ignora_bit <= 1'b1;
                  run_cnt      <= 3'd1;
                  last_bit     <= sync2;
                end else begin
                  o_Erro_Flag <= 1'b1;
                  state       <= ERROR_WAIT;
                end
              end else if (sync2 == last_bit) begin
                run_cnt <= run_cnt + 3'd1;
              end else begin
                run_cnt  <= 3'd1;
                last_bit <= sync2;
              end
            end

            if (sync2 && (rec_inc_c == IDLE_N)) begin
              state       <= BUS_IDLE;
              o_Bus_Idle  <= 1'b1;
              o_Erro_Flag <= 1'b0;
            end
          end
        end

        default: state <= IDLE_WAIT;
      endcase
    end
  end

endmodule
